// File: rtl/tomasulo_rs_age.sv
// tomasulo_rs_age: age-ordered reservation station.
// Holds up to N dispatched instructions. Each entry snoops CDB_N result buses
// for its pending operands. Among the ready entries, the oldest one is requested
// for issue. The grant comes from the CDB arbiter and is also gated by the
// scheduler reservation vector.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   sch_r                         CDB slot reservations (bit LATENCY_N = our slot taken)
//   flush                         discard every entry
//   dis_*                         dispatch handshake and instruction fields
//   cdb_vld/cdb_tag/cdb_wdata     CDB snoop ports (element k at [k*X +: X])
//   cdb_req, cdb_gnt              issue request / same-cycle grant
//   occ                           number of valid entries
//   iss_*                         registered issue outputs
module tomasulo_rs_age #(
  parameter int N         = 4,
  parameter int W         = 32,
  parameter int TAG_W     = 4,
  parameter int ROBID_W   = 4,
  parameter int OP_W      = 4,
  parameter int REG_W     = 5,
  parameter int CDB_N     = 2,
  parameter int LATENCY_N = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LATENCY_N:0]     sch_r,
  input  logic                   flush,
  input  logic                   dis_vld,
  output logic                   dis_rdy,
  input  logic [OP_W-1:0]        dis_op,
  input  logic [1:0]             dis_busy,
  input  logic [2*W-1:0]         dis_opr,
  input  logic [TAG_W-1:0]       dis_tag,
  input  logic [ROBID_W-1:0]     dis_robid,
  input  logic [REG_W-1:0]       dis_wa,
  input  logic [W-1:0]           dis_imm,
  input  logic [CDB_N-1:0]       cdb_vld,
  input  logic [CDB_N*TAG_W-1:0] cdb_tag,
  input  logic [CDB_N*W-1:0]     cdb_wdata,
  output logic                   cdb_req,
  input  logic                   cdb_gnt,
  output logic [$clog2(N+1)-1:0] occ,
  output logic                   iss_vld_r,
  output logic [OP_W-1:0]        iss_op,
  output logic [2*W-1:0]         iss_rdata,
  output logic [TAG_W-1:0]       iss_tag,
  output logic [ROBID_W-1:0]     iss_robid,
  output logic [REG_W-1:0]       iss_wa,
  output logic [W-1:0]           iss_imm
);
  localparam int OCC_W = $clog2(N + 1);

  // Returns {hit, data}. Ports are scanned from the highest index down, so the
  // lowest matching port is the one that wins.
  function automatic logic [W:0] snoop(input logic [TAG_W-1:0] t,
                                       input logic [CDB_N-1:0] v,
                                       input logic [CDB_N*TAG_W-1:0] tg,
                                       input logic [CDB_N*W-1:0] d);
    logic [W:0] r;
    r = '0;
    for (int p = CDB_N - 1; p >= 0; p--)
      if (v[p] && tg[p*TAG_W +: TAG_W] == t) r = {1'b1, d[p*W +: W]};
    return r;
  endfunction

  logic [N-1:0]       vld_q, rdy_q, alloc_oh, sel_oh, iss_oh, free;
  logic [N*N-1:0]     older;  // older[i*N+j]: entry i is older than entry j
  logic [OP_W-1:0]    op_q    [N];
  logic [2*W-1:0]     opr_q   [N];
  logic [TAG_W-1:0]   tag_q   [N];
  logic [ROBID_W-1:0] robid_q [N];
  logic [REG_W-1:0]   wa_q    [N];
  logic [W-1:0]       imm_q   [N];
  logic [OCC_W-1:0]   occ_c;
  logic [1:0]         dis_hit, dis_busy_eff;
  logic [2*W-1:0]     dis_cap, dis_opr_eff;
  logic               alloc_en, iss_en;
  logic               unused_sch;

  assign unused_sch = &{1'b0, sch_r[LATENCY_N-1:0]};

  always_comb begin
    occ_c = '0;
    for (int i = 0; i < N; i++) occ_c = occ_c + OCC_W'(vld_q[i]);
  end
  assign occ     = occ_c;
  assign dis_rdy = (occ_c != OCC_W'(N));

  // The lowest free entry is isolated by the two's-complement trick.
  assign alloc_en = dis_vld & dis_rdy & ~flush;
  assign free     = ~vld_q;
  assign alloc_oh = (free & (~free + N'(1))) & {N{alloc_en}};

  // A dispatching operand can pick up a result that is broadcast in the same cycle.
  for (genvar gk = 0; gk < 2; gk++) begin : g_dis
    assign {dis_hit[gk], dis_cap[gk*W +: W]} =
      snoop(dis_opr[gk*W +: TAG_W], cdb_vld, cdb_tag, cdb_wdata);
    assign dis_opr_eff[gk*W +: W] = (dis_busy[gk] & dis_hit[gk]) ?
                                    dis_cap[gk*W +: W] : dis_opr[gk*W +: W];
  end
  assign dis_busy_eff = dis_busy & ~dis_hit;

  assign cdb_req = (|rdy_q) & ~sch_r[LATENCY_N] & ~flush;
  assign iss_en  = cdb_req & cdb_gnt;
  assign iss_oh  = sel_oh & {N{iss_en}};

  for (genvar gi = 0; gi < N; gi++) begin : g_ent
    logic               vld_reg, rdy_reg;
    logic [1:0]         busy_reg, busy_next, wake_hit;
    logic [2*W-1:0]     opr_reg, wake_data;
    logic [OP_W-1:0]    op_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [ROBID_W-1:0] robid_reg;
    logic [REG_W-1:0]   wa_reg;
    logic [W-1:0]       imm_reg;
    logic [N-1:0]       older_than_me;

    for (genvar gk = 0; gk < 2; gk++) begin : g_wake
      assign {wake_hit[gk], wake_data[gk*W +: W]} =
        snoop(opr_reg[gk*W +: TAG_W], cdb_vld, cdb_tag, cdb_wdata);
    end
    assign busy_next = busy_reg & ~wake_hit;

    // Ready is set on the same edge that clears the last busy bit. It is
    // therefore visible in the cycle after the match.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_reg  <= 1'b0;
        rdy_reg  <= 1'b0;
        busy_reg <= 2'b00;
      end else if (flush) begin
        vld_reg  <= 1'b0;
        rdy_reg  <= 1'b0;
        busy_reg <= 2'b00;
      end else if (alloc_oh[gi]) begin
        vld_reg  <= 1'b1;
        busy_reg <= dis_busy_eff;
        rdy_reg  <= ~|dis_busy_eff;
      end else if (iss_oh[gi]) begin
        vld_reg  <= 1'b0;
        rdy_reg  <= 1'b0;
      end else if (vld_reg) begin
        busy_reg <= busy_next;
        rdy_reg  <= ~|busy_next;
      end
    end

    always_ff @(posedge clk) begin
      if (alloc_oh[gi]) begin
        op_reg    <= dis_op;
        opr_reg   <= dis_opr_eff;
        tag_reg   <= dis_tag;
        robid_reg <= dis_robid;
        wa_reg    <= dis_wa;
        imm_reg   <= dis_imm;
      end else if (vld_reg) begin
        for (int k = 0; k < 2; k++)
          if (busy_reg[k] && wake_hit[k]) opr_reg[k*W +: W] <= wake_data[k*W +: W];
      end
    end

    assign vld_q[gi]   = vld_reg;
    assign rdy_q[gi]   = rdy_reg;
    assign op_q[gi]    = op_reg;
    assign opr_q[gi]   = opr_reg;
    assign tag_q[gi]   = tag_reg;
    assign robid_q[gi] = robid_reg;
    assign wa_q[gi]    = wa_reg;
    assign imm_q[gi]   = imm_reg;

    // Age matrix: a new entry is younger than every other entry. Diagonal bits
    // are constant zero, so only N*(N-1) of the bits are stored in flops.
    for (genvar gj = 0; gj < N; gj++) begin : g_age
      if (gi == gj) begin : g_diag
        assign older[gi*N + gj] = 1'b0;
      end else begin : g_off
        logic age_reg;
        always_ff @(posedge clk or posedge rst) begin
          if (rst)               age_reg <= 1'b0;
          else if (flush)        age_reg <= 1'b0;
          else if (alloc_oh[gi]) age_reg <= 1'b0;
          else if (alloc_oh[gj]) age_reg <= 1'b1;
        end
        assign older[gi*N + gj] = age_reg;
      end
      assign older_than_me[gj] = older[gj*N + gi];
    end

    // An entry is selected when no other ready entry is older than it.
    assign sel_oh[gi] = rdy_reg & ~|(rdy_q & older_than_me);
  end

  logic [OP_W-1:0]    mux_op;
  logic [2*W-1:0]     mux_opr;
  logic [TAG_W-1:0]   mux_tag;
  logic [ROBID_W-1:0] mux_robid;
  logic [REG_W-1:0]   mux_wa;
  logic [W-1:0]       mux_imm;

  always_comb begin
    mux_op = '0; mux_opr = '0; mux_tag = '0; mux_robid = '0; mux_wa = '0; mux_imm = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_oh[i]) begin
        mux_op    = mux_op    | op_q[i];
        mux_opr   = mux_opr   | opr_q[i];
        mux_tag   = mux_tag   | tag_q[i];
        mux_robid = mux_robid | robid_q[i];
        mux_wa    = mux_wa    | wa_q[i];
        mux_imm   = mux_imm   | imm_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) iss_vld_r <= 1'b0;
    else     iss_vld_r <= iss_en;
  end

  always_ff @(posedge clk) begin
    if (iss_en) begin
      iss_op    <= mux_op;
      iss_rdata <= mux_opr;
      iss_tag   <= mux_tag;
      iss_robid <= mux_robid;
      iss_wa    <= mux_wa;
      iss_imm   <= mux_imm;
    end
  end
endmodule

// File: tb/tb_tomasulo_rs_age.sv
// Directed bench for tomasulo_rs_age. Each expected issue is pushed to a
// scoreboard when its stimulus is driven. The entry is popped and compared
// whenever iss_vld_r is seen high.
module tb_tomasulo_rs_age;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sch_r;
  logic        flush, dis_vld, dis_rdy;
  logic [3:0]  dis_op;
  logic [1:0]  dis_busy;
  logic [63:0] dis_opr;
  logic [3:0]  dis_tag, dis_robid;
  logic [4:0]  dis_wa;
  logic [31:0] dis_imm;
  logic [1:0]  cdb_vld;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_wdata;
  logic        cdb_req, cdb_gnt;
  logic [2:0]  occ;
  logic        iss_vld_r;
  logic [3:0]  iss_op, iss_tag, iss_robid;
  logic [63:0] iss_rdata;
  logic [4:0]  iss_wa;
  logic [31:0] iss_imm;

  tomasulo_rs_age dut (
    .clk(clk), .rst(rst), .sch_r(sch_r), .flush(flush),
    .dis_vld(dis_vld), .dis_rdy(dis_rdy), .dis_op(dis_op), .dis_busy(dis_busy),
    .dis_opr(dis_opr), .dis_tag(dis_tag), .dis_robid(dis_robid), .dis_wa(dis_wa),
    .dis_imm(dis_imm), .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
    .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .occ(occ), .iss_vld_r(iss_vld_r),
    .iss_op(iss_op), .iss_rdata(iss_rdata), .iss_tag(iss_tag), .iss_robid(iss_robid),
    .iss_wa(iss_wa), .iss_imm(iss_imm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] rdata;
    logic [3:0]  tag;
    logic [3:0]  robid;
    logic [4:0]  wa;
    logic [31:0] imm;
  } iss_t;

  iss_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r0,
                      input logic [3:0] tag, input logic [3:0] robid,
                      input logic [4:0] wa, input logic [31:0] imm);
    iss_t e;
    e.op = op; e.rdata = {r1, r0}; e.tag = tag; e.robid = robid; e.wa = wa; e.imm = imm;
    sb.push_back(e);
  endtask

  // Advance one clock and check any issue that appears after the edge.
  task automatic tick();
    iss_t e;
    @(posedge clk);
    #1;
    if (iss_vld_r === 1'b1) begin
      if (sb.size() == 0) begin
        chk("iss_unexpected", 64'(iss_vld_r), 64'd0);
      end else begin
        e = sb.pop_front();
        $display("issue op=%0h rdata=%0h tag=%0h", iss_op, iss_rdata, iss_tag);
        chk("iss_op", 64'(iss_op), 64'(e.op));
        chk("iss_rdata", iss_rdata, e.rdata);
        chk("iss_tag", 64'(iss_tag), 64'(e.tag));
        chk("iss_robid", 64'(iss_robid), 64'(e.robid));
        chk("iss_wa", 64'(iss_wa), 64'(e.wa));
        chk("iss_imm", 64'(iss_imm), 64'(e.imm));
      end
    end
  endtask

  task automatic set_dis(input logic [3:0] op, input logic [1:0] busy,
                         input logic [31:0] o0, input logic [31:0] o1,
                         input logic [3:0] tag, input logic [3:0] robid,
                         input logic [4:0] wa, input logic [31:0] imm);
    dis_vld = 1'b1; dis_op = op; dis_busy = busy; dis_opr = {o1, o0};
    dis_tag = tag; dis_robid = robid; dis_wa = wa; dis_imm = imm;
  endtask

  task automatic cdb(input int port, input logic [3:0] tag, input logic [31:0] data);
    cdb_vld[port] = 1'b1;
    cdb_tag[port*4 +: 4] = tag;
    cdb_wdata[port*32 +: 32] = data;
  endtask

  task automatic clr();
    dis_vld = 1'b0; dis_busy = 2'b00; cdb_vld = 2'b00; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sch_r = '0; flush = 0; dis_vld = 0; dis_op = 0; dis_busy = 0;
    dis_opr = 0; dis_tag = 0; dis_robid = 0; dis_wa = 0; dis_imm = 0;
    cdb_vld = 0; cdb_tag = 0; cdb_wdata = 0; cdb_gnt = 0;
    #3;
    chk("rst_dis_rdy", 64'(dis_rdy), 64'd1);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_cdb_req", 64'(cdb_req), 64'd0);
    chk("rst_iss_vld", 64'(iss_vld_r), 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Ready at dispatch: request at t+1, issue at t+2.
    cdb_gnt = 1'b1;
    set_dis(4'h1, 2'b00, 32'd5, 32'd7, 4'h9, 4'h2, 5'd3, 32'h1234);
    push(4'h1, 32'd7, 32'd5, 4'h9, 4'h2, 5'd3, 32'h1234);
    tick(); clr();
    chk("t1_occ1", 64'(occ), 64'd1);
    chk("t1_req", 64'(cdb_req), 64'd1);
    tick();
    chk("t1_iss_vld", 64'(iss_vld_r), 64'd1);
    chk("t1_occ0", 64'(occ), 64'd0);

    // Wakeup on port 1 after an unrelated broadcast.
    set_dis(4'h2, 2'b01, 32'd3, 32'h22, 4'h4, 4'h3, 5'd4, 32'h0);
    tick(); clr();
    chk("t2_req_a", 64'(cdb_req), 64'd0);
    tick();
    cdb(0, 4'h2, 32'h55);
    tick(); clr();
    chk("t2_req_b", 64'(cdb_req), 64'd0);
    tick();
    cdb(1, 4'h3, 32'hAA);
    push(4'h2, 32'h22, 32'hAA, 4'h4, 4'h3, 5'd4, 32'h0);
    tick(); clr();
    chk("t2_req_c", 64'(cdb_req), 64'd1);
    tick();

    // Same-cycle capture; both ports match, so the lowest port wins.
    set_dis(4'h3, 2'b11, 32'd6, 32'd6, 4'h6, 4'h7, 5'd8, 32'hBEEF);
    cdb(0, 4'h6, 32'h11);
    cdb(1, 4'h6, 32'h99);
    push(4'h3, 32'h11, 32'h11, 4'h6, 4'h7, 5'd8, 32'hBEEF);
    tick(); clr();
    chk("t3_req", 64'(cdb_req), 64'd1);
    tick();

    // Fill all four entries, each waiting on the tag k.
    cdb_gnt = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_dis(4'(k), 2'b01, 32'(k), 32'h100 + 32'(k), 4'(k), 4'(k), 5'(k), 32'(k));
      tick(); clr();
    end
    chk("full_dis_rdy", 64'(dis_rdy), 64'd0);
    chk("full_occ", 64'(occ), 64'd4);
    chk("full_req", 64'(cdb_req), 64'd0);
    set_dis(4'hE, 2'b00, 32'h1, 32'h2, 4'hE, 4'hE, 5'd14, 32'hE);
    tick(); clr();
    chk("full_ignored_occ", 64'(occ), 64'd4);
    // Free entry 0, and attempt a dispatch in the grant cycle while still full.
    cdb(0, 4'h1, 32'hB1);
    tick(); clr();
    cdb_gnt = 1'b1;
    set_dis(4'hF, 2'b00, 32'h3, 32'h4, 4'hF, 4'hF, 5'd15, 32'hF);
    push(4'h1, 32'h101, 32'hB1, 4'h1, 4'h1, 5'd1, 32'h1);
    chk("grant_full_dis_rdy", 64'(dis_rdy), 64'd0);
    chk("grant_req", 64'(cdb_req), 64'd1);
    tick(); clr();
    cdb_gnt = 1'b0;
    chk("freed_dis_rdy", 64'(dis_rdy), 64'd1);
    chk("freed_occ", 64'(occ), 64'd3);
    // Redispatch into entry 0. It is now younger than the tag-2 entry.
    set_dis(4'h5, 2'b01, 32'd5, 32'h105, 4'h5, 4'h5, 5'd5, 32'h5);
    tick(); clr();
    chk("redis_occ", 64'(occ), 64'd4);
    cdb(0, 4'h5, 32'hC5);
    cdb(1, 4'h2, 32'hC2);
    tick(); clr();
    sch_r = 3'b100;
    #1;
    chk("sch_blocks_req", 64'(cdb_req), 64'd0);
    sch_r = 3'b000;
    #1;
    chk("sch_free_req", 64'(cdb_req), 64'd1);
    cdb_gnt = 1'b1;
    push(4'h2, 32'h102, 32'hC2, 4'h2, 4'h2, 5'd2, 32'h2);
    push(4'h5, 32'h105, 32'hC5, 4'h5, 4'h5, 5'd5, 32'h5);
    tick();
    tick();
    cdb_gnt = 1'b0;
    chk("age_occ", 64'(occ), 64'd2);

    // Flush with three entries while the grant is high.
    set_dis(4'h6, 2'b00, 32'h61, 32'h62, 4'h6, 4'h6, 5'd6, 32'h6);
    tick(); clr();
    chk("pre_flush_occ", 64'(occ), 64'd3);
    chk("pre_flush_req", 64'(cdb_req), 64'd1);
    set_dis(4'h7, 2'b00, 32'h71, 32'h72, 4'h7, 4'h7, 5'd7, 32'h7);
    flush = 1'b1; cdb_gnt = 1'b1;
    #1;
    chk("flush_req", 64'(cdb_req), 64'd0);
    tick(); clr();
    cdb_gnt = 1'b0;
    chk("flush_occ", 64'(occ), 64'd0);
    chk("flush_iss_vld", 64'(iss_vld_r), 64'd0);
    chk("flush_dis_rdy", 64'(dis_rdy), 64'd1);
    tick();
    chk("post_flush_req", 64'(cdb_req), 64'd0);

    // Asynchronous reset during a wakeup, with an issue just registered.
    cdb_gnt = 1'b1;
    set_dis(4'h8, 2'b00, 32'h81, 32'h82, 4'h8, 4'h8, 5'd8, 32'h8);
    push(4'h8, 32'h82, 32'h81, 4'h8, 4'h8, 5'd8, 32'h8);
    tick(); clr();
    set_dis(4'h9, 2'b01, 32'd7, 32'h92, 4'h9, 4'h9, 5'd9, 32'h9);
    tick(); clr();
    cdb_gnt = 1'b0;
    chk("pre_rst_iss_vld", 64'(iss_vld_r), 64'd1);
    chk("pre_rst_occ", 64'(occ), 64'd1);
    cdb(0, 4'h7, 32'h77);
    #2 rst = 1'b1;
    #1;
    chk("arst_iss_vld", 64'(iss_vld_r), 64'd0);
    chk("arst_occ", 64'(occ), 64'd0);
    chk("arst_dis_rdy", 64'(dis_rdy), 64'd1);
    chk("arst_req", 64'(cdb_req), 64'd0);
    clr();
    @(posedge clk); #1; rst = 1'b0;
    tick();
    chk("post_rst_occ", 64'(occ), 64'd0);
    chk("post_rst_req", 64'(cdb_req), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tomasulo_rs_age.md
# tomasulo_rs_age

Parametrised, age-ordered reservation station for the Tomasulo pipeline. Holds up to N dispatched instructions, snoops CDB_N parallel result buses for pending operands and issues the oldest ready entry, not the lowest-index one. Adds dispatch back-pressure, a full flush and an occupancy count. Sits between dispatch and one functional unit; issue is gated by the CDB arbiter and scheduler reservation vector.

## Interface
- N, 4: station entries (≥2)
- W, 32: operand/immediate data width
- TAG_W, 4: producer tag width (≤ W)
- ROBID_W, 4: ROB id width
- OP_W, 4: opcode width
- REG_W, 5: architectural write-address width
- CDB_N, 2: number of CDB snoop ports
- LATENCY_N, 2: FU latency; index into sch_r
- Ports (packed vectors, element k at [k*X +: X]):
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- sch_r  in  LATENCY_N+1  CDB slot reservation vector; bit LATENCY_N set = slot taken
- flush  in  1  discard all entries
- dis_vld  in  1  dispatch valid
- dis_rdy  out  1  station can accept (some entry free)
- dis_op  in  OP_W  opcode
- dis_busy  in  2  operand k waits on a tag
- dis_opr  in  2*W  operand k: data, or tag in [TAG_W-1:0] when busy
- dis_tag, dis_robid, dis_wa, dis_imm  in  TAG_W/ROBID_W/REG_W/W  passthrough fields
- cdb_vld  in  CDB_N  port valid
- cdb_tag  in  CDB_N*TAG_W  port tag
- cdb_wdata  in  CDB_N*W  port data
- cdb_req  out  1  station has an issuable entry
- cdb_gnt  in  1  arbiter grant, same cycle as cdb_req
- occ  out  $clog2(N+1)  valid-entry count
- iss_vld_r  out  1  registered issue valid
- iss_op, iss_rdata (2*W), iss_tag, iss_robid, iss_wa, iss_imm  out  registered issue fields

## Operation
- Per entry: vld, rdy, busy[1:0], operand data/tag, passthrough fields.
- Age matrix older[i][j] (i older than j), N*(N-1) flops. On allocation of i: older[j][i]=1, older[i][j]=0 for every j.
- Allocation: when dis_vld & dis_rdy & ~flush, lowest-index free entry is written.
- Same-cycle capture: a dispatching busy operand whose tag matches any valid CDB port is stored as data with busy=0.
- Wakeup: each valid busy operand compares against all CDB ports every cycle; on match data captured, busy cleared. Multiple matching ports: lowest port index wins.
- rdy set on the cycle after both busy bits are clear; cleared on issue.
- Select: oldest entry with rdy=1 (no other rdy entry older than it).
- cdb_req = any rdy & ~sch_r[LATENCY_N] & ~flush.
- Issue: cdb_req & cdb_gnt; selected entry's vld/rdy cleared, fields registered into iss_*. Immediate ignored by the station.
- occ = popcount(vld); dis_rdy = (occ != N), from registered state only.
- Flush: all vld/rdy cleared next cycle, dispatch dropped, no request, iss_vld_r=0 next cycle.
- dis_vld while dis_rdy=0: ignored, no state change.

## Timing
- Reset: all vld/rdy/older=0, iss_vld_r=0, cdb_req=0, dis_rdy=1, occ=0; iss_* data fields undefined until first issue.
- Ready-at-dispatch: dispatch cycle t -> cdb_req at t+1 -> iss_vld_r at t+2 if granted at t+1.
- Wakeup: CDB match at t -> cdb_req at t+1.
- No grant: request held; selection may change if an older entry becomes ready.
- Entry freed at grant cycle t; dis_rdy and occ reflect it at t+1; reusable at t+1.
- Full with simultaneous grant: dispatch at t still rejected (dis_rdy from state).
- At most one issue and one allocation per cycle; both may occur together.
- rst mid-operation: all state cleared immediately, independent of clk.

## Test plan
- Ready dispatch: dis_busy=00, opr 5/7, gnt held 1 -> cdb_req at t+1, iss_vld_r at t+2, iss_rdata={7,5}, occ 1 then 0.
- Wakeup: dispatch busy op0 tag 3; at t+4 port1 tag3 data 0xAA -> cdb_req at t+5, iss_rdata[0]=0xAA; unrelated tag 2 earlier -> no change.
- Dispatch/CDB same cycle: dispatch busy tag 6 while port0 broadcasts tag6 data 0x11 -> request next cycle, data 0x11.
- Age order: fill entries with tags 1,2,3,4 (dispatch order), free entry 0, redispatch tag 5 into entry 0; broadcast tags 5 and 2 same cycle -> tag-2 entry issues first, then tag-5.
- Full/back-pressure: 4 busy entries -> dis_rdy=0, occ=4, extra dis_vld ignored; after one grant dis_rdy=1 next cycle. sch_r[2]=1 -> cdb_req=0 despite ready entry.
- Flush/reset: flush with 3 entries and grant-high -> no issue, occ=0 next cycle; async rst mid-wakeup -> outputs at reset values before next clk edge.
